// File: rtl/visibility_accumulate_pkg.sv
// Shared constants and types for the visibility accumulator.
// Field order of packed {re, im} words and readout FSM encoding.
package visibility_accumulate_pkg;

  localparam int DEF_WIDTH      = 4;
  localparam int DEF_ACCUM_BITS = 24;
  localparam int DEF_COUNT      = 16;
  localparam int DEF_FRAMES     = 64;

  // Slot index of each field inside a packed word (re upper)
  localparam int SLOT_RE = 1;
  localparam int SLOT_IM = 0;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_READ = 2'd1,
    RD_SEND = 2'd2
  } rd_state_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/visibility_accumulate_if.sv
// AXI4-Stream style output bundle of the accumulator.
// Master drives beats, slave applies backpressure.
interface visibility_accumulate_if
  import visibility_accumulate_pkg::*;
#(
  parameter int DW = 2 * DEF_ACCUM_BITS
);

  logic          tvalid;
  logic          tready;
  logic          tlast;
  logic [DW-1:0] tdata;

  modport master (
    output tvalid,
    output tlast,
    output tdata,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tlast,
    input  tdata,
    output tready
  );

endinterface

// File: rtl/visibility_bank_ram.sv
// Two-bank accumulator store; bank bit is the address MSB.
// Port A reads/writes for accumulation, port B reads out.
module visibility_bank_ram
  import visibility_accumulate_pkg::*;
#(
  parameter int AW = 5,
  parameter int DW = 48
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          a_en,
  input  logic [AW-1:0] a_addr,
  output logic [DW-1:0] a_data,
  input  logic          w_en,
  input  logic [AW-1:0] w_addr,
  input  logic [DW-1:0] w_data,
  input  logic          b_en,
  input  logic [AW-1:0] b_addr,
  output logic [DW-1:0] b_data
);

  logic [DW-1:0] mem [2**AW];

  // Accumulate port: write-back and sync read
  always_ff @(posedge clock) begin
    if (w_en) mem[w_addr] <= w_data;
    if (a_en) a_data <= mem[a_addr];
  end

  // Readout port; its register feeds the output bus directly
  always_ff @(posedge clock) begin
    if (!reset_n)  b_data <= '0;
    else if (b_en) b_data <= mem[b_addr];
  end

endmodule

// File: rtl/visibility_accumulate.sv
// Integrates correlator partial sums into ping-pong banks
// and streams each finished integration out with backpressure.
module visibility_accumulate
  import visibility_accumulate_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ACCUM_BITS = DEF_ACCUM_BITS,
  parameter int COUNT      = DEF_COUNT,
  parameter int FRAMES     = DEF_FRAMES
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             frame_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] rdata_i,
  input  logic [WIDTH-1:0] idata_i,
  visibility_accumulate_if.master m,
  output logic             sat_o,
  output logic             overflow_o,
  output logic             err_o
);

  localparam int AB = ACCUM_BITS;
  localparam int DW = 2 * AB;
  localparam int IW = clog2_min1(COUNT);
  localparam int CW = $clog2(COUNT + 1);
  localparam int FW = clog2_min1(FRAMES);
  localparam int AW = IW + 1;

  logic          frame_q;
  logic [CW-1:0] idx;
  logic [FW-1:0] fcnt;
  logic          wb;

  rd_state_t     state;
  logic [IW-1:0] rd_idx;
  logic          tvalid_q;
  logic          tlast_q;

  logic          p_vld;
  logic          p_ovw;
  logic [AW-1:0] p_addr;
  logic [WIDTH-1:0] p_re;
  logic [WIDTH-1:0] p_im;

  logic          fe;
  logic          in_range;
  logic          beat_ok;
  logic          last_frame;
  logic          done;
  logic          start;
  logic          hazard;
  logic          b_en;
  logic          sat_hit;

  logic [AW-1:0] a_addr;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] a_data;
  logic [DW-1:0] b_data;
  logic [DW-1:0] w_data;

  logic [AB-1:0] old_re;
  logic [AB-1:0] old_im;
  logic [AB:0]   sum_re;
  logic [AB:0]   sum_im;
  logic [AB-1:0] new_re;
  logic [AB-1:0] new_im;

  assign fe         = frame_q & ~frame_i;
  assign in_range   = idx < CW'(COUNT);
  assign beat_ok    = valid_i & in_range;
  assign last_frame = fcnt == FW'(FRAMES - 1);
  assign done       = fe & last_frame;
  assign start      = done & (state == RD_IDLE);

  assign a_addr = {wb, idx[IW-1:0]};
  assign b_addr = {~wb, rd_idx};

  assign old_re = a_data[SLOT_RE*AB +: AB];
  assign old_im = a_data[SLOT_IM*AB +: AB];
  assign sum_re = {1'b0, old_re} + (AB+1)'(p_re);
  assign sum_im = {1'b0, old_im} + (AB+1)'(p_im);

  // Overwrite on the first frame, else saturating add
  always_comb begin
    new_re = sum_re[AB-1:0];
    new_im = sum_im[AB-1:0];
    if (p_ovw) begin
      new_re = AB'(p_re);
      new_im = AB'(p_im);
    end else begin
      if (sum_re[AB]) new_re = '1;
      if (sum_im[AB]) new_im = '1;
    end
  end

  // Pack the write-back word in the shared field order
  always_comb begin
    w_data = '0;
    w_data[SLOT_RE*AB +: AB] = new_re;
    w_data[SLOT_IM*AB +: AB] = new_im;
  end

  assign sat_hit = p_vld & ~p_ovw & (sum_re[AB] | sum_im[AB]);

  // A readout read must not overtake a pending write-back
  assign hazard = p_vld & (p_addr == b_addr);
  assign b_en   = (state == RD_READ) & ~hazard;

  visibility_bank_ram #(
    .AW (AW),
    .DW (DW)
  ) u_ram (
    .clock   (clock),
    .reset_n (reset_n),
    .a_en    (beat_ok),
    .a_addr  (a_addr),
    .a_data  (a_data),
    .w_en    (p_vld),
    .w_addr  (p_addr),
    .w_data  (w_data),
    .b_en    (b_en),
    .b_addr  (b_addr),
    .b_data  (b_data)
  );

  // Frame envelope history and per-frame beat index
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      frame_q <= 1'b0;
      idx     <= '0;
    end else begin
      frame_q <= frame_i;
      if (valid_i) begin
        if (in_range) idx <= idx + CW'(1);
      end else if (!frame_i) begin
        idx <= '0;
      end
    end
  end

  // Read-modify-write pipeline: capture beat while RAM reads
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      p_vld  <= 1'b0;
      p_ovw  <= 1'b0;
      p_addr <= '0;
      p_re   <= '0;
      p_im   <= '0;
    end else begin
      p_vld  <= beat_ok;
      p_ovw  <= fcnt == '0;
      p_addr <= a_addr;
      p_re   <= rdata_i;
      p_im   <= idata_i;
    end
  end

  // Frame counting, bank swap and sticky status
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fcnt       <= '0;
      wb         <= 1'b0;
      sat_o      <= 1'b0;
      overflow_o <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      if (fe) fcnt <= last_frame ? '0 : fcnt + FW'(1);
      if (start) wb <= ~wb;
      if (done && state != RD_IDLE) overflow_o <= 1'b1;
      if (sat_hit) sat_o <= 1'b1;
      if (valid_i && !in_range) err_o <= 1'b1;
    end
  end

  // Readout FSM: read a word, then hold it until accepted
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= RD_IDLE;
      rd_idx   <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      unique case (state)
        RD_IDLE: begin
          if (start) begin
            state  <= RD_READ;
            rd_idx <= '0;
          end
        end
        RD_READ: begin
          if (!hazard) begin
            state    <= RD_SEND;
            tvalid_q <= 1'b1;
            tlast_q  <= rd_idx == IW'(COUNT - 1);
          end
        end
        RD_SEND: begin
          if (m.tready) begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            if (tlast_q) begin
              state <= RD_IDLE;
            end else begin
              rd_idx <= rd_idx + IW'(1);
              state  <= RD_READ;
            end
          end
        end
        default: state <= RD_IDLE;
      endcase
    end
  end

  assign m.tvalid = tvalid_q;
  assign m.tlast  = tlast_q;
  assign m.tdata  = b_data;

endmodule

// File: tb/tb_visibility_accumulate.sv
// Directed bench: two accumulator widths fed the same stream,
// checked against an integration-level scoreboard.
module tb_visibility_accumulate;

  localparam int COUNT  = 4;
  localparam int FRAMES = 2;
  localparam int WIDTH  = 4;
  localparam int AB0    = 8;
  localparam int AB1    = 4;

  typedef struct {
    int re;
    int im;
    bit last;
  } beat_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic frame_i = 1'b0;
  logic valid_i = 1'b0;
  logic [WIDTH-1:0] rdata_i = '0;
  logic [WIDTH-1:0] idata_i = '0;
  logic tready = 1'b1;
  logic sat0, ovf0, err0;
  logic sat1, ovf1, err1;

  visibility_accumulate_if #(.DW(2*AB0)) m0 ();
  visibility_accumulate_if #(.DW(2*AB1)) m1 ();

  assign m0.tready = tready;
  assign m1.tready = tready;

  always #5 clock = ~clock;

  visibility_accumulate #(
    .WIDTH(WIDTH), .ACCUM_BITS(AB0),
    .COUNT(COUNT), .FRAMES(FRAMES)
  ) dut0 (
    .clock(clock), .reset_n(reset_n),
    .frame_i(frame_i), .valid_i(valid_i),
    .rdata_i(rdata_i), .idata_i(idata_i),
    .m(m0),
    .sat_o(sat0), .overflow_o(ovf0), .err_o(err0)
  );

  visibility_accumulate #(
    .WIDTH(WIDTH), .ACCUM_BITS(AB1),
    .COUNT(COUNT), .FRAMES(FRAMES)
  ) dut1 (
    .clock(clock), .reset_n(reset_n),
    .frame_i(frame_i), .valid_i(valid_i),
    .rdata_i(rdata_i), .idata_i(idata_i),
    .m(m1),
    .sat_o(sat1), .overflow_o(ovf1), .err_o(err1)
  );

  int cmp = 0;
  int bad = 0;
  int cyc = 0;
  int done_cyc = 0;
  bit lat_armed = 0;

  beat_t q0[$];
  beat_t q1[$];
  int acc_re[2][COUNT];
  int acc_im[2][COUNT];
  int fidx = 0;
  bit m_sat[2];
  bit m_ovf[2];
  bit m_err = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    cmp++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sat_add(input int d, input int a, input int b);
    int mx;
    int s;
    mx = (d == 0) ? (1 << AB0) - 1 : (1 << AB1) - 1;
    s = a + b;
    if (s > mx) begin
      s = mx;
      m_sat[d] = 1;
    end
    return s;
  endfunction

  function automatic void model_beat(input int i, input int r, input int im);
    if (i >= COUNT) begin
      m_err = 1;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (fidx == 0) begin
          acc_re[d][i] = r;
          acc_im[d][i] = im;
        end else begin
          acc_re[d][i] = sat_add(d, acc_re[d][i], r);
          acc_im[d][i] = sat_add(d, acc_im[d][i], im);
        end
      end
    end
  endfunction

  function automatic void model_frame_end();
    if (fidx != FRAMES - 1) begin
      fidx++;
    end else begin
      fidx = 0;
      if (q0.size() != 0) begin
        m_ovf[0] = 1;
      end else begin
        for (int i = 0; i < COUNT; i++)
          q0.push_back('{acc_re[0][i], acc_im[0][i], i == COUNT - 1});
        done_cyc = cyc;
        lat_armed = 1;
      end
      if (q1.size() != 0) begin
        m_ovf[1] = 1;
      end else begin
        for (int i = 0; i < COUNT; i++)
          q1.push_back('{acc_re[1][i], acc_im[1][i], i == COUNT - 1});
      end
    end
  endfunction

  // Per-cycle output check against the scoreboard
  logic [2*AB0-1:0] hold0;
  logic [2*AB1-1:0] hold1;
  bit hl0, hl1;
  bit stall0 = 0;
  bit stall1 = 0;

  always @(negedge clock) begin
    beat_t b;
    if (!reset_n) begin
      stall0 = 0;
      stall1 = 0;
    end else begin
      if (lat_armed && m0.tvalid) begin
        check("first_beat_latency", cyc - done_cyc, 2);
        lat_armed = 0;
      end
      if (stall0 && m0.tvalid) begin
        check("hold_data0", m0.tdata, hold0);
        check("hold_last0", m0.tlast, hl0);
      end
      if (stall0) check("hold_valid0", m0.tvalid, 1);
      if (stall1 && m1.tvalid) begin
        check("hold_data1", m1.tdata, hold1);
        check("hold_last1", m1.tlast, hl1);
      end
      stall0 = m0.tvalid && !tready;
      stall1 = m1.tvalid && !tready;
      hold0 = m0.tdata;
      hold1 = m1.tdata;
      hl0 = m0.tlast;
      hl1 = m1.tlast;
      if (m0.tvalid && tready) begin
        cmp++;
        if (q0.size() == 0) begin
          bad++;
          $display("FAIL extra_beat0: got %h expected none", m0.tdata);
        end else begin
          b = q0.pop_front();
          if (m0.tdata[15:8] != b.re[7:0] ||
              m0.tdata[7:0] != b.im[7:0] || m0.tlast != b.last) begin
            bad++;
            $display("FAIL beat0: got re %0d im %0d last %0d expected re %0d im %0d last %0d",
                     m0.tdata[15:8], m0.tdata[7:0], m0.tlast, b.re, b.im, b.last);
          end
        end
      end
      if (m1.tvalid && tready) begin
        cmp++;
        if (q1.size() == 0) begin
          bad++;
          $display("FAIL extra_beat1: got %h expected none", m1.tdata);
        end else begin
          b = q1.pop_front();
          if (m1.tdata[7:4] != b.re[3:0] ||
              m1.tdata[3:0] != b.im[3:0] || m1.tlast != b.last) begin
            bad++;
            $display("FAIL beat1: got re %0d im %0d last %0d expected re %0d im %0d last %0d",
                     m1.tdata[7:4], m1.tdata[3:0], m1.tlast, b.re, b.im, b.last);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input int n, input int re[8], input int im[8]);
    for (int i = 0; i < n; i++) begin
      frame_i = 1'b1;
      valid_i = 1'b1;
      rdata_i = 4'(re[i]);
      idata_i = 4'(im[i]);
      model_beat(i, re[i], im[i]);
      tick();
    end
    frame_i = 1'b0;
    valid_i = 1'b0;
    model_frame_end();
    tick();
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    check(name, q0.size() + q1.size(), 0);
    repeat (3) tick();
  endtask

  task automatic wait_q0(input int sz);
    int n = 0;
    while (q0.size() != sz && n < 300) begin
      tick();
      n++;
    end
    check("wait_q0_size", q0.size(), sz);
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_sat0"}, sat0, m_sat[0]);
    check({tag, "_sat1"}, sat1, m_sat[1]);
    check({tag, "_ovf0"}, ovf0, m_ovf[0]);
    check({tag, "_ovf1"}, ovf1, m_ovf[1]);
    check({tag, "_err0"}, err0, m_err);
    check({tag, "_err1"}, err1, m_err);
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    fidx = 0;
    m_sat = '{0, 0};
    m_ovf = '{0, 0};
    m_err = 0;
    lat_armed = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    check("rst_tvalid0", m0.tvalid, 0);
    check("rst_tvalid1", m1.tvalid, 0);
    check("rst_tdata0", m0.tdata, 0);
    check("rst_tlast0", m0.tlast, 0);
    check_flags("rst");

    // Basic two-frame integration
    send_frame(4, '{1,2,3,4,0,0,0,0}, '{0,1,2,3,0,0,0,0});
    send_frame(4, '{1,2,3,4,0,0,0,0}, '{0,1,2,3,0,0,0,0});
    check("t1_nbeats", q0.size(), 4);
    for (int i = 0; i < q0.size(); i++) begin
      check("t1_model_re", q0[i].re, 2 * (i + 1));
      check("t1_model_im", q0[i].im, 2 * i);
    end
    wait_drain("t1_drain");
    check("t1_sat0", sat0, 0);
    check_flags("t1");

    // Backpressure during the second beat
    send_frame(4, '{1,2,3,4,0,0,0,0}, '{0,1,2,3,0,0,0,0});
    send_frame(4, '{1,2,3,4,0,0,0,0}, '{0,1,2,3,0,0,0,0});
    wait_q0(3);
    tready = 1'b0;
    tick();
    tick();
    check("t2_stall_valid", m0.tvalid, 1);
    check("t2_stall_data", m0.tdata, 16'h0402);
    repeat (3) tick();
    tready = 1'b1;
    wait_drain("t2_drain");
    check_flags("t2");

    // Saturation on the narrow accumulator only
    send_frame(4, '{15,15,15,15,0,0,0,0}, '{1,2,3,4,0,0,0,0});
    send_frame(4, '{15,15,15,15,0,0,0,0}, '{1,2,3,4,0,0,0,0});
    check("t3_model_re1", q1[0].re, 15);
    check("t3_model_re0", q0[0].re, 30);
    check("t3_model_im1", q1[3].im, 8);
    wait_drain("t3_drain");
    check("t3_sat1", sat1, 1);
    check("t3_sat0", sat0, 0);
    check_flags("t3");

    // Overflow: B completes while A is stuck in readout
    tready = 1'b0;
    send_frame(4, '{1,2,3,4,0,0,0,0}, '{1,1,1,1,0,0,0,0});
    send_frame(4, '{1,2,3,4,0,0,0,0}, '{1,1,1,1,0,0,0,0});
    repeat (4) tick();
    send_frame(4, '{7,7,7,7,0,0,0,0}, '{7,7,7,7,0,0,0,0});
    send_frame(4, '{7,7,7,7,0,0,0,0}, '{7,7,7,7,0,0,0,0});
    repeat (2) tick();
    check("t4_ovf0", ovf0, 1);
    check("t4_model_ovf", m_ovf[0], 1);
    tready = 1'b1;
    wait_drain("t4a_drain");
    send_frame(4, '{3,0,1,2,0,0,0,0}, '{4,4,4,4,0,0,0,0});
    send_frame(4, '{3,0,1,2,0,0,0,0}, '{4,4,4,4,0,0,0,0});
    check("t4_model_c_re", q0[0].re, 6);
    wait_drain("t4c_drain");
    check_flags("t4");

    // Reset in the middle of a readout
    send_frame(4, '{5,5,5,5,0,0,0,0}, '{5,5,5,5,0,0,0,0});
    send_frame(4, '{5,5,5,5,0,0,0,0}, '{5,5,5,5,0,0,0,0});
    wait_q0(3);
    reset_n = 1'b0;
    model_reset();
    tick();
    check("t5_tvalid_after_rst", m0.tvalid, 0);
    check("t5_sat1_cleared", sat1, 0);
    tick();
    reset_n = 1'b1;
    tick();
    send_frame(4, '{2,3,4,5,0,0,0,0}, '{1,0,1,0,0,0,0,0});
    send_frame(4, '{2,3,4,5,0,0,0,0}, '{1,0,1,0,0,0,0,0});
    check("t5_model_re", q0[3].re, 10);
    wait_drain("t5_drain");
    check_flags("t5");

    // Over-long frame: extra beat dropped
    send_frame(5, '{1,2,3,4,9,0,0,0}, '{1,1,1,1,9,0,0,0});
    send_frame(4, '{1,1,1,1,0,0,0,0}, '{0,0,0,0,0,0,0,0});
    check("t6_model_re0", q0[0].re, 2);
    check("t6_model_re3", q0[3].re, 5);
    check("t6_model_im3", q0[3].im, 1);
    wait_drain("t6_drain");
    check("t6_err0", err0, 1);
    check_flags("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
